// File: rtl/delta_pkg.sv
// Shared constants, types and step-adaptation rules for the delta-modulation codec.
// The DeltaADC encoder imports this same package so both ends adapt the step identically.
package delta_pkg;

    localparam int W        = 8;
    localparam int STEP_MIN = 1;
    localparam int STEP_MAX = 32;
    localparam int RUN_LEN  = 3;
    localparam int FILL_W   = $clog2(RUN_LEN + 1);

    typedef logic [W-1:0]       sample_t;
    typedef logic [RUN_LEN-1:0] hist_t;
    typedef logic [FILL_W-1:0]  fill_t;

    localparam sample_t MIDSCALE   = sample_t'(1 << (W - 1));
    localparam sample_t STEP_MIN_S = sample_t'(STEP_MIN);
    localparam sample_t STEP_MAX_S = sample_t'(STEP_MAX);
    localparam fill_t   FILL_FULL  = fill_t'(RUN_LEN);

    // A run only counts once the history holds RUN_LEN real bits, not reset zeros.
    function automatic logic run_detected(input hist_t h, input fill_t f);
        return (f == FILL_FULL) && ((h == '1) || (h == '0));
    endfunction

    function automatic sample_t step_double(input sample_t s);
        logic [W:0] d;
        d = {s, 1'b0};
        return (d > {1'b0, STEP_MAX_S}) ? STEP_MAX_S : d[W-1:0];
    endfunction

    function automatic sample_t step_halve(input sample_t s);
        sample_t h;
        h = s >> 1;
        return (h < STEP_MIN_S) ? STEP_MIN_S : h;
    endfunction

    // Step for the bit being accepted, given the already-updated history and fill.
    function automatic sample_t next_step(input logic adaptive, input hist_t h,
                                          input fill_t f, input sample_t s);
        if (!adaptive)
            return STEP_MIN_S;
        else if (run_detected(h, f))
            return step_double(s);
        else
            return step_halve(s);
    endfunction

endpackage

// File: rtl/delta_pwm.sv
// PWM renderer: free-running counter, duty latched only at counter wrap so a
// period is never torn, and a registered comparator output.
module delta_pwm #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic         pwm
);

    logic [W-1:0] pcnt_reg;
    logic [W-1:0] duty_reg;
    logic         pwm_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_reg <= '0;
            duty_reg <= W'(1 << (W - 1));
            pwm_reg  <= 1'b0;
        end else begin
            pcnt_reg <= pcnt_reg + W'(1);
            if (pcnt_reg == '1)
                duty_reg <= level;
            pwm_reg <= (pcnt_reg < duty_reg);
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: rtl/delta_demod.sv
// Delta-modulation decoder: integrates a 1-bit up/down stream with a fixed or
// CVSD-style adaptive step into a clamped W-bit sample, rendered as PWM.
module delta_demod
    import delta_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         adaptive,
    input  logic         sat_clr,
    output logic [W-1:0] sample_out,
    output logic         sample_valid,
    output logic [W-1:0] step_out,
    output logic         sat_flag,
    output logic         pwm_out
);

    sample_t    value_reg, value_next;
    sample_t    step_reg,  step_next;
    hist_t      hist_reg,  hist_next;
    fill_t      fill_reg,  fill_next;
    logic       valid_reg, valid_next;
    logic       sat_reg,   sat_next;
    logic       accept;
    logic       clamp;
    logic [W:0] sum;

    assign accept = en & bit_valid;

    always_comb begin
        value_next = value_reg;
        step_next  = step_reg;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        valid_next = 1'b0;
        clamp      = 1'b0;
        sum        = '0;
        if (accept) begin
            hist_next = {hist_reg[RUN_LEN-2:0], bit_in};
            fill_next = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + fill_t'(1);
            step_next = next_step(adaptive, hist_next, fill_next, step_reg);
            // Bit W is the carry on the way up and the borrow on the way down.
            if (bit_in)
                sum = {1'b0, value_reg} + {1'b0, step_next};
            else
                sum = {1'b0, value_reg} - {1'b0, step_next};
            clamp      = sum[W];
            value_next = clamp ? (bit_in ? '1 : '0) : sum[W-1:0];
            valid_next = 1'b1;
        end
        // A clamp in the same cycle as a clear leaves the flag set.
        sat_next = clamp | (sat_reg & ~sat_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_reg <= MIDSCALE;
            step_reg  <= STEP_MIN_S;
            hist_reg  <= '0;
            fill_reg  <= '0;
            valid_reg <= 1'b0;
            sat_reg   <= 1'b0;
        end else begin
            value_reg <= value_next;
            step_reg  <= step_next;
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            valid_reg <= valid_next;
            sat_reg   <= sat_next;
        end
    end

    delta_pwm #(.W(W)) u_pwm (
        .clk   (clk),
        .rst   (rst),
        .level (value_reg),
        .pwm   (pwm_out)
    );

    assign sample_out   = value_reg;
    assign sample_valid = valid_reg;
    assign step_out     = step_reg;
    assign sat_flag     = sat_reg;

endmodule

// File: tb/tb_delta_demod.sv
// Directed bench for delta_demod with hand-computed expected samples, steps and PWM duty.
module tb_delta_demod;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       adaptive = 1'b0;
    logic       sat_clr = 1'b0;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic [7:0] step_out;
    logic       sat_flag;
    logic       pwm_out;

    int n_checks = 0;
    int n_errors = 0;

    delta_demod dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .adaptive     (adaptive),
        .sat_clr      (sat_clr),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .step_out     (step_out),
        .sat_flag     (sat_flag),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bit_valid = 1'b0;
        en = 1'b1;
        adaptive = 1'b0;
        sat_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated strobe; returns at the negedge after the accepting posedge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_in = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pwm_out) hi++;
        end
    endtask

    int fx_bits [7] = '{1, 1, 1, 1, 1, 0, 0};
    int fx_samp [7] = '{129, 130, 131, 132, 133, 132, 131};
    int ad_bits [6] = '{1, 1, 1, 1, 1, 0};
    int ad_step [6] = '{1, 1, 2, 4, 8, 4};
    int ad_samp [6] = '{129, 130, 132, 136, 144, 140};
    int hi;

    initial begin
        // Asynchronous reset with no clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_sample", sample_out, 128);
        check("rst_step", step_out, 1);
        check("rst_sat", sat_flag, 0);
        check("rst_pwm", pwm_out, 0);
        check("rst_valid", sample_valid, 0);

        // Fixed step
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_bit(fx_bits[i][0]);
            check($sformatf("fix%0d_sample", i), sample_out, fx_samp[i]);
            check($sformatf("fix%0d_step", i), step_out, 1);
            check($sformatf("fix%0d_valid", i), sample_valid, 1);
            @(negedge clk);
            check($sformatf("fix%0d_valid_drop", i), sample_valid, 0);
        end

        // Adaptive step, then switch back to fixed mid-stream
        do_reset();
        adaptive = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_bit(ad_bits[i][0]);
            check($sformatf("ad%0d_step", i), step_out, ad_step[i]);
            check($sformatf("ad%0d_sample", i), sample_out, ad_samp[i]);
        end
        adaptive = 1'b0;
        send_bit(1'b0);
        check("ad_off_step", step_out, 1);
        check("ad_off_sample", sample_out, 139);

        // Long run of ones: step caps at 32, sample clamps at 255
        do_reset();
        adaptive = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_bit(1'b1);
            if (i == 7) begin
                check("run8_sample", sample_out, 224);
                check("run8_sat", sat_flag, 0);
            end
            if (i == 8) check("run9_sat", sat_flag, 1);
        end
        check("run_sample", sample_out, 255);
        check("run_step", step_out, 32);
        check("run_sat", sat_flag, 1);
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        check("satclr_alone", sat_flag, 0);
        check("satclr_sample", sample_out, 255);
        @(negedge clk);
        sat_clr = 1'b1;
        bit_in = 1'b1;
        bit_valid = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        bit_valid = 1'b0;
        check("satclr_with_clamp", sat_flag, 1);

        // Reset asserted mid-cycle with a strobe pending
        @(negedge clk);
        bit_in = 1'b1;
        bit_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("midrst_sample", sample_out, 128);
        check("midrst_step", step_out, 1);
        check("midrst_sat", sat_flag, 0);
        check("midrst_valid", sample_valid, 0);
        check("midrst_pwm", pwm_out, 0);
        @(negedge clk);
        rst = 1'b0;
        bit_valid = 1'b0;
        @(negedge clk);
        check("relrst_sample", sample_out, 128);
        check("relrst_valid", sample_valid, 0);

        // Disabled decoder ignores strobes
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("dis%0d_valid", i), sample_valid, 0);
            bit_in = 1'b1;
            bit_valid = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        check("dis_valid", sample_valid, 0);
        check("dis_sample", sample_out, 128);

        // Back-to-back strobes
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("b2b%0d_valid", i), sample_valid, 1);
                check($sformatf("b2b%0d_sample", i), sample_out, 128 + i);
            end
            bit_in = 1'b1;
            bit_valid = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        check("b2b8_valid", sample_valid, 1);
        check("b2b8_sample", sample_out, 136);
        @(negedge clk);
        check("b2b_valid_drop", sample_valid, 0);

        // PWM: drop sample to 64 mid-period
        do_reset();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bit_in = 1'b0;
            bit_valid = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        check("pwm_sample64", sample_out, 64);
        repeat (30) @(negedge clk);
        check("pwm_old_duty_held", pwm_out, 1);
        repeat (210) @(negedge clk);
        count_high(256, hi);
        check("pwm_duty64", hi, 64);

        // PWM: sample to 0, then one more down bit clamps
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bit_in = 1'b0;
            bit_valid = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        check("pwm_sample0", sample_out, 0);
        check("zero_sat_clear", sat_flag, 0);
        send_bit(1'b0);
        check("low_clamp_sample", sample_out, 0);
        check("low_clamp_sat", sat_flag, 1);
        repeat (300) @(negedge clk);
        count_high(256, hi);
        check("pwm_duty0", hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
